// File: rtl/mult_host_driver_pkg.sv
// rtl/mult_host_driver_pkg.sv - shared types and mailbox map for the multiplier host driver
//
// Contents:
//   host_state_t     sequencer states, also exported on state_o
//   CONTROL/DATA_IN/DATA_OUT/STATUS
//                    mailbox word addresses, identical to the multiplier-side controller map
//   STATUS_DONE_BIT  STATUS bit raised by the core when the product is ready
//   CTRL_START_BIT   CONTROL bit that starts the core
//   CNT_W            width of the poll timeout counter
//   ctrl_word()      builds a CONTROL word with only the start bit driven
package host_driver_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_CTRL_SET,
        POLL_SET,
        RD_RESULT,
        WR_CTRL_CLR,
        POLL_CLR,
        RESP
    } host_state_t;

    localparam logic [3:0] CONTROL  = 4'h0;
    localparam logic [3:0] DATA_IN  = 4'h1;
    localparam logic [3:0] DATA_OUT = 4'h2;
    localparam logic [3:0] STATUS   = 4'h3;

    localparam int STATUS_DONE_BIT = 0;
    localparam int CTRL_START_BIT  = 0;

    localparam int CNT_W = 16;

    function automatic logic [31:0] ctrl_word(input logic start);
        logic [31:0] w;
        w = '0;
        w[CTRL_START_BIT] = start;
        return w;
    endfunction

endpackage

// File: rtl/mult_host_driver_if.sv
// rtl/mult_host_driver_if.sv - host-port bus of the mailbox RAM
//
// Signals (named from the driver's point of view):
//   address_o    word address
//   write_o      one-cycle write strobe
//   read_o       one-cycle read strobe
//   writedata_o  write data, valid with write_o
//   readdata_i   read data, valid READ_LATENCY cycles after read_o
// Modports: master = driver, slave = RAM port.
interface mult_host_driver_if;

    logic [3:0]  address_o;
    logic        write_o;
    logic        read_o;
    logic [31:0] writedata_o;
    logic [31:0] readdata_i;

    modport master (
        output address_o,
        output write_o,
        output read_o,
        output writedata_o,
        input  readdata_i
    );

    modport slave (
        input  address_o,
        input  write_o,
        input  read_o,
        input  writedata_o,
        output readdata_i
    );

endinterface

// File: rtl/mult_host_driver_poller.sv
// rtl/mult_host_driver_poller.sv - STATUS poll sequencing and timeout shared by both poll states
//
// Ports:
//   clk_i, rst_i     clock, asynchronous active-low reset
//   start_i          this cycle is the one before a poll state; issue the first STATUS read
//   active_i         a poll state is current
//   expect_i         STATUS done-bit value that ends the poll
//   status_bit_i     done bit of the read data bus
//   issue_o          register a STATUS read strobe at the coming edge
//   match_o          read data is valid this cycle and equals expect_i
//   timeout_o        poll state has lasted TIMEOUT_CYCLES cycles without a match
module host_driver_poller
    import host_driver_pkg::*;
#(
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic active_i,
    input  logic expect_i,
    input  logic status_bit_i,
    output logic issue_o,
    output logic match_o,
    output logic timeout_o
);

    localparam int LAT_W = $clog2(READ_LATENCY + 1) + 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // lat_q counts cycles since the last read strobe (0 in the strobe cycle),
    // so read data is valid exactly when it reaches READ_LATENCY.
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sample;

    always_comb begin
        sample    = active_i && (lat_q == LAT_LAST);
        match_o   = sample && (status_bit_i == expect_i);
        // A match seen on the last allowed cycle still wins over the timeout.
        timeout_o = active_i && !match_o && (cnt_q >= TMO_LAST);
        issue_o   = start_i || (sample && !match_o && !timeout_o);

        lat_d = lat_q;
        cnt_d = cnt_q;
        if (issue_o) begin
            lat_d = '0;
        end else if (active_i && (lat_q != LAT_LAST)) begin
            lat_d = lat_q + LAT_W'(1);
        end
        if (start_i) begin
            cnt_d = '0;
        end else if (active_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lat_q <= '0;
            cnt_q <= '0;
        end else begin
            lat_q <= lat_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mult_host_driver.sv
// rtl/mult_host_driver.sv - host-side sequencer for the multiplier mailbox
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-low reset
//   op_valid_i/op_ready_o     operand stream handshake (ready only in IDLE)
//   a_i, b_i                  4-bit operands
//   res_valid_o/res_ready_i   result stream handshake
//   res_o                     8-bit product (DATA_OUT[7:0])
//   err_o                     a poll phase timed out for this result
//   bus                       host port of the mailbox RAM (master side)
//   state_o                   current sequencer state
module mult_host_driver
    import host_driver_pkg::*;
#(
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                op_valid_i,
    output logic                op_ready_o,
    input  logic [3:0]          a_i,
    input  logic [3:0]          b_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [7:0]          res_o,
    output logic                err_o,
    mult_host_driver_if.master  bus,
    output host_state_t         state_o
);

    localparam int LAT_W = $clog2(READ_LATENCY + 1) + 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY);

    host_state_t      state_q, state_d;
    logic [3:0]       addr_q, addr_d;
    logic             write_q, write_d;
    logic             read_q, read_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [7:0]       res_q, res_d;
    logic             err_q, err_d;
    logic             res_valid_q, res_valid_d;
    logic [LAT_W-1:0] rd_cnt_q, rd_cnt_d;

    logic poll_start, poll_active, poll_expect;
    logic poll_issue, poll_match, poll_timeout;
    logic unused_rdata;

    assign unused_rdata = ^bus.readdata_i[31:8];

    // The first STATUS read is registered on the edge into the poll state,
    // so it is requested from the write state just before it.
    assign poll_start  = (state_q == WR_CTRL_SET) || (state_q == WR_CTRL_CLR);
    assign poll_active = (state_q == POLL_SET) || (state_q == POLL_CLR);
    assign poll_expect = (state_q == POLL_SET);

    host_driver_poller #(
        .READ_LATENCY   (READ_LATENCY),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_poller (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (poll_start),
        .active_i     (poll_active),
        .expect_i     (poll_expect),
        .status_bit_i (bus.readdata_i[STATUS_DONE_BIT]),
        .issue_o      (poll_issue),
        .match_o      (poll_match),
        .timeout_o    (poll_timeout)
    );

    // Bus outputs are registered: each state's strobe is set up on the edge
    // that enters it, so the strobe is seen during that state's first cycle.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = 1'b0;
        read_d      = 1'b0;
        res_d       = res_q;
        err_d       = err_q;
        res_valid_d = res_valid_q;
        rd_cnt_d    = rd_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (op_valid_i) begin
                    // The DATA_IN write word is the operand latch.
                    state_d = WR_DATA;
                    err_d   = 1'b0;
                    write_d = 1'b1;
                    addr_d  = DATA_IN;
                    wdata_d = {24'h0, b_i, a_i};
                end
            end
            WR_DATA: begin
                state_d = WR_CTRL_SET;
                write_d = 1'b1;
                addr_d  = CONTROL;
                wdata_d = ctrl_word(1'b1);
            end
            WR_CTRL_SET: begin
                state_d = POLL_SET;
            end
            POLL_SET: begin
                if (poll_match) begin
                    state_d  = RD_RESULT;
                    read_d   = 1'b1;
                    addr_d   = DATA_OUT;
                    rd_cnt_d = '0;
                end else if (poll_timeout) begin
                    err_d   = 1'b1;
                    res_d   = 8'h00;
                    state_d = WR_CTRL_CLR;
                    write_d = 1'b1;
                    addr_d  = CONTROL;
                    wdata_d = ctrl_word(1'b0);
                end
            end
            RD_RESULT: begin
                if (rd_cnt_q == LAT_LAST) begin
                    res_d   = bus.readdata_i[7:0];
                    state_d = WR_CTRL_CLR;
                    write_d = 1'b1;
                    addr_d  = CONTROL;
                    wdata_d = ctrl_word(1'b0);
                end else begin
                    rd_cnt_d = rd_cnt_q + LAT_W'(1);
                end
            end
            WR_CTRL_CLR: begin
                state_d = POLL_CLR;
            end
            POLL_CLR: begin
                if (poll_match) begin
                    state_d     = RESP;
                    res_valid_d = 1'b1;
                end else if (poll_timeout) begin
                    err_d       = 1'b1;
                    state_d     = RESP;
                    res_valid_d = 1'b1;
                end
            end
            RESP: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Poll reads never coincide with a write: they are only requested
        // from states that issue no write on the same edge.
        if (poll_issue) begin
            read_d = 1'b1;
            addr_d = STATUS;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            addr_q      <= CONTROL;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            wdata_q     <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            rd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            read_q      <= read_d;
            wdata_q     <= wdata_d;
            res_q       <= res_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    assign op_ready_o      = (state_q == IDLE);
    assign state_o         = state_q;
    assign res_valid_o     = res_valid_q;
    assign res_o           = res_q;
    assign err_o           = err_q;
    assign bus.address_o   = addr_q;
    assign bus.write_o     = write_q;
    assign bus.read_o      = read_q;
    assign bus.writedata_o = wdata_q;

endmodule

// File: tb/tb_mult_host_driver.sv
// tb/tb_mult_host_driver.sv - self-checking bench for mult_host_driver with a mailbox RAM + core model
module tb_mult_host_driver;
    import host_driver_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        op_valid, op_ready, res_valid, res_ready, err_s, bw, br;
    logic [1:0][3:0]   a_s, b_s, baddr;
    logic [1:0][7:0]   res_s;
    logic [1:0][31:0]  bwdata;
    host_state_t       st [2];

    logic [31:0] mem [2][4];
    logic [31:0] rp  [2][3];
    int          tmr [2];
    bit          nost [2];
    logic [35:0] wlog0 [$];

    int n_checks = 0;
    int n_fail   = 0;
    int overlap  = 0;

    // Instance 0: READ_LATENCY=1, TIMEOUT_CYCLES=16. Instance 1: READ_LATENCY=3.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mult_host_driver_if bus ();
        mult_host_driver #(
            .READ_LATENCY   (g == 0 ? 1 : 3),
            .TIMEOUT_CYCLES (g == 0 ? 16 : 64)
        ) dut (
            .clk_i       (clk),
            .rst_i       (rst_n),
            .op_valid_i  (op_valid[g]),
            .op_ready_o  (op_ready[g]),
            .a_i         (a_s[g]),
            .b_i         (b_s[g]),
            .res_valid_o (res_valid[g]),
            .res_ready_i (res_ready[g]),
            .res_o       (res_s[g]),
            .err_o       (err_s[g]),
            .bus         (bus),
            .state_o     (st[g])
        );
        assign bw[g]          = bus.write_o;
        assign br[g]          = bus.read_o;
        assign baddr[g]       = bus.address_o;
        assign bwdata[g]      = bus.writedata_o;
        assign bus.readdata_i = rp[g][g == 0 ? 0 : 2];
    end

    // Mailbox RAM + multiplier core: STATUS rises 4 cycles after CONTROL start,
    // clears 2 cycles after CONTROL drops. Read data outside the valid slot is random.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < 2; g++) begin
                for (int i = 0; i < 4; i++) mem[g][i] <= '0;
                for (int i = 0; i < 3; i++) rp[g][i] <= 32'hDEADBEEF;
                tmr[g] <= 0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (mem[g][CONTROL][0] && !mem[g][STATUS][0] && !nost[g]) begin
                    if (tmr[g] == 3) begin
                        mem[g][DATA_OUT] <= {24'h0, 8'(mem[g][DATA_IN][3:0]) * 8'(mem[g][DATA_IN][7:4])};
                        mem[g][STATUS]   <= 32'h1;
                        tmr[g]           <= 0;
                    end else begin
                        tmr[g] <= tmr[g] + 1;
                    end
                end else if (!mem[g][CONTROL][0] && mem[g][STATUS][0]) begin
                    if (tmr[g] == 1) begin
                        mem[g][STATUS] <= 32'h0;
                        tmr[g]         <= 0;
                    end else begin
                        tmr[g] <= tmr[g] + 1;
                    end
                end else begin
                    tmr[g] <= 0;
                end
                if (bw[g]) mem[g][baddr[g][1:0]] <= bwdata[g];
                rp[g][0] <= br[g] ? mem[g][baddr[g][1:0]] : $urandom;
                rp[g][1] <= rp[g][0];
                rp[g][2] <= rp[g][1];
            end
            if (bw[0]) wlog0.push_back({baddr[0], bwdata[0]});
        end
    end

    always @(negedge clk) begin
        if ((bw & br) != 2'b00) overlap++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one operation on instance g, starting and ending at a falling edge.
    task automatic run_op(input int g, input logic [3:0] a, input logic [3:0] b, input int hold,
                          input logic [7:0] exp_res, input logic exp_err, input bit chk_log);
        int n;
        int act;
        int bad;
        logic [7:0] r0;
        if (chk_log) wlog0.delete();
        a_s[g] = a;
        b_s[g] = b;
        op_valid[g] = 1'b1;
        n = 0;
        while (!op_ready[g] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready[g]) check_eq($sformatf("accept%0d", g), {63'h0, op_ready[g]}, 64'h1);
        @(negedge clk);
        op_valid[g] = 1'b0;
        n = 0;
        while (!res_valid[g] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("res_valid%0d", g), {63'h0, res_valid[g]}, 64'h1);
        check_eq($sformatf("res%0d a=%0d b=%0d", g, a, b), {56'h0, res_s[g]}, {56'h0, exp_res});
        check_eq($sformatf("err%0d", g), {63'h0, err_s[g]}, {63'h0, exp_err});
        r0  = res_s[g];
        act = 0;
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bw[g] || br[g]) act++;
            if (!res_valid[g] || res_s[g] !== r0) bad++;
        end
        if (hold > 0) begin
            check_eq("hold_stable", 64'(bad), 64'h0);
            check_eq("hold_quiet", 64'(act), 64'h0);
        end
        res_ready[g] = 1'b1;
        @(negedge clk);
        res_ready[g] = 1'b0;
        check_eq($sformatf("idle%0d", g), 64'(st[g]), 64'(IDLE));
        check_eq($sformatf("res_drop%0d", g), {63'h0, res_valid[g]}, 64'h0);
        if (chk_log) begin
            check_eq("wlog_len", 64'(wlog0.size()), 64'h3);
            if (wlog0.size() == 3) begin
                check_eq("wr_data_in", 64'(wlog0[0]), 64'({DATA_IN, 24'h0, b, a}));
                check_eq("wr_ctrl_set", 64'(wlog0[1]), 64'({CONTROL, 32'h1}));
                check_eq("wr_ctrl_clr", 64'(wlog0[2]), 64'({CONTROL, 32'h0}));
            end
        end
    endtask

    initial begin
        logic [3:0] x0, y0, x1, y1;
        logic [7:0] e0, e1;
        int h0, h1, n;
        op_valid  = '0;
        res_ready = '0;
        a_s       = '0;
        b_s       = '0;
        nost[0]   = 1'b0;
        nost[1]   = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_op_ready", {63'h0, op_ready[0]}, 64'h1);
        check_eq("rst_res_valid", {63'h0, res_valid[0]}, 64'h0);
        check_eq("rst_res", {56'h0, res_s[0]}, 64'h0);
        check_eq("rst_err", {63'h0, err_s[0]}, 64'h0);
        check_eq("rst_write", {63'h0, bw[0]}, 64'h0);
        check_eq("rst_read", {63'h0, br[0]}, 64'h0);
        check_eq("rst_addr", {60'h0, baddr[0]}, 64'(CONTROL));
        check_eq("rst_wdata", {32'h0, bwdata[0]}, 64'h0);
        check_eq("rst_state", 64'(st[0]), 64'(IDLE));

        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 4'd3, 4'd5, 0, 8'h0F, 1'b0, 1'b1);
        run_op(0, 4'd15, 4'd15, 0, 8'hE1, 1'b0, 1'b1);
        run_op(0, 4'd0, 4'd9, 0, 8'h00, 1'b0, 1'b1);
        run_op(0, 4'd3, 4'd5, 10, 8'h0F, 1'b0, 1'b1);

        nost[0] = 1'b1;
        run_op(0, 4'd3, 4'd5, 2, 8'h00, 1'b1, 1'b1);
        nost[0] = 1'b0;
        run_op(0, 4'd1, 4'd1, 0, 8'h01, 1'b0, 1'b1);

        run_op(1, 4'd9, 4'd6, 0, 8'h36, 1'b0, 1'b0);

        // Asynchronous reset while polling STATUS.
        a_s[0] = 4'd4;
        b_s[0] = 4'd4;
        op_valid[0] = 1'b1;
        @(negedge clk);
        op_valid[0] = 1'b0;
        n = 0;
        while (st[0] != POLL_SET && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_poll_set", 64'(st[0]), 64'(POLL_SET));
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_state", 64'(st[0]), 64'(IDLE));
        check_eq("arst_op_ready", {63'h0, op_ready[0]}, 64'h1);
        check_eq("arst_read", {63'h0, br[0]}, 64'h0);
        check_eq("arst_addr", {60'h0, baddr[0]}, 64'(CONTROL));
        check_eq("arst_res", {56'h0, res_s[0]}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(0, 4'd2, 4'd7, 0, 8'h0E, 1'b0, 1'b1);

        for (int it = 0; it < 20; it++) begin
            x0 = 4'($urandom);
            y0 = 4'($urandom);
            x1 = 4'($urandom);
            y1 = 4'($urandom);
            e0 = x0 * y0;
            e1 = x1 * y1;
            h0 = $urandom_range(0, 3);
            h1 = $urandom_range(0, 3);
            fork
                run_op(0, x0, y0, h0, e0, 1'b0, 1'b1);
                run_op(1, x1, y1, h1, e1, 1'b0, 1'b0);
            join
        end

        check_eq("strobe_overlap", 64'(overlap), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
